spi_adc_sampler: RTL and testbench
==================================

# spi_adc_sampler

Drives a 12-bit serial ADC (AD7476-class: 4 leading zeros, then 12 data bits MSB-first, 16 SCLK per conversion) at a fixed sample rate. It optionally box-averages 2^AVG_LOG2 conversions and presents the result as a 16-bit left-justified `adc_data` word with a one-cycle `adc_valid` strobe. It sits between the IR range sensor's ADC pins and the ADC-to-distance lookup stage, and is the producer of the `adc_data` value that stage consumes.

## Interface
- CLK_DIV, 5: clk cycles per SCLK half-period (H); ≥ 2.
- SAMPLE_PERIOD, 1000: clk cycles between conversion start opportunities.
- QUIET_CYCLES, 5: minimum clk cycles `cs_n` stays high after a conversion; ≥ 1.
- AVG_LOG2, 2: log2 of conversions per output word; range 0–4.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clock clk.
- enable  in  1  high = run periodic conversions.
- miso  in  1  ADC serial data out.
- cs_n  out  1  ADC chip select, active low.
- sclk  out  1  ADC serial clock, idle high.
- raw_sample  out  12  most recent single conversion result.
- adc_data  out  16  averaged result, {avg[11:0], 4'b0}.
- adc_valid  out  1  one-cycle pulse when `adc_data` updates.
- busy  out  1  high while not in IDLE.

## Operation
- Reset values: `cs_n`=1, `sclk`=1, `raw_sample`=0, `adc_data`=0, `adc_valid`=0, `busy`=0. All counters, the shift register and the accumulator are cleared, and the FSM is in IDLE. Reset takes effect immediately, including mid-conversion, and forces `cs_n`/`sclk` high at once.
- Rate counter: counts 0..SAMPLE_PERIOD-1 and wraps while `enable`=1. It is held at 0 while `enable`=0.
- A start request occurs when the counter equals 0 and `enable`=1.
  - It is honoured only in IDLE.
  - A start request in any other state is dropped, not queued.
- FSM states: IDLE → CONV → QUIET → IDLE.
- IDLE:
  - `cs_n`=1, `sclk`=1.
  - On a start request, go to CONV.
  - If `enable`=0, clear the accumulator and the conversion count.
- CONV:
  - `cs_n`=0.
  - The half-period counter toggles `sclk` every H cycles, starting with a fall.
  - `miso` is shifted into a 16-bit register at the clk edge that drives `sclk` high. It is sampled directly, with no synchronizer; data is stable since the prior falling edge.
  - After the 16th rising edge, hold `sclk` high for H cycles, then drive `cs_n`=1 and go to QUIET.
- Capture: `raw_sample` = shift[11:0]. The leading 4 bits (shift[15:12]) are discarded regardless of value.
- Averaging:
  - Accumulator width is 12+AVG_LOG2 bits, so it cannot overflow.
  - On each capture, add `raw_sample` to the accumulator and increment the count.
  - When the count reaches 2^AVG_LOG2:
    - `adc_data` = {acc[11+AVG_LOG2:AVG_LOG2], 4'b0}, i.e. truncating divide.
    - Pulse `adc_valid`.
    - Clear the accumulator and the count.
  - With AVG_LOG2=0, every conversion produces an output.
- QUIET: hold for QUIET_CYCLES, then go to IDLE.
- `enable` falling mid-CONV: the current conversion completes normally, including capture and accumulation. No new start occurs, and the partial average is discarded once back in IDLE.
- `adc_data` and `raw_sample` hold their values between updates.

## Timing
- T0 = clk edge entering CONV, where `cs_n` falls. With H = CLK_DIV:
  - Falling `sclk` edges occur at T0+(2k−1)·H, for k=1..16.
  - Rising `sclk` edges occur at T0+2k·H.
  - `cs_n` rises at T0+33·H.
- `raw_sample` updates at T0+33·H+1. On averaging-window completion, `adc_data` updates and `adc_valid`=1 for exactly that one cycle.
- Earliest next `cs_n` fall: T0+33·H+QUIET_CYCLES+1, subject to the next start request.
- Conversion occupancy is 33·H+QUIET_CYCLES+1 cycles. SAMPLE_PERIOD must exceed this; otherwise every other start request is dropped.
- Defaults give SCLK = clk/10, and one `adc_valid` per 4·SAMPLE_PERIOD cycles in steady state.
- `busy` rises with `cs_n` fall and falls on return to IDLE.

## Test plan
- Reset: assert `reset` mid-CONV → `cs_n`=1 and `sclk`=1 immediately, all outputs 0. After release with `enable`=1, the first `cs_n` fall occurs at the next counter wrap.
- Single conversion (AVG_LOG2=0): ADC model serves 0x0ABC → 16 `sclk` rising edges while `cs_n`=0, `raw_sample`=0xABC, `adc_data`=0xABC0, one-cycle `adc_valid` at T0+33·H+1.
- Leading bits ignored: model drives 0xFFFF → `raw_sample`=0xFFF, `adc_data`=0xFFF0. Model drives 0xF000 → `adc_data`=0x0000.
- Averaging (AVG_LOG2=2): samples 0x100, 0x200, 0x300, 0x404 → `adc_valid` only after the 4th conversion, `adc_data`=0x2810. The next window starts from a cleared accumulator.
- `enable` dropped mid-CONV (AVG_LOG2=0): the conversion finishes with `raw_sample` and `adc_valid` produced, then no further `cs_n` activity. Re-enable after two conversions of a partial window (AVG_LOG2=2): the partial window is discarded and the next `adc_valid` comes after 4 fresh conversions.
- Overrun: SAMPLE_PERIOD=100, CLK_DIV=5 → start requests during CONV are dropped. `cs_n` low width is always 165 cycles and is never shortened.

Source files
------------

// File: rtl/spi_adc_sampler_if.sv
// Pin and result bundle of the SPI ADC sampler: ADC pins, run control and averaged output.
interface spi_adc_sampler_if;
    logic        enable;
    logic        miso;
    logic        cs_n;
    logic        sclk;
    logic [11:0] raw_sample;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic        busy;

    modport master (
        input  enable, miso,
        output cs_n, sclk, raw_sample, adc_data, adc_valid, busy
    );

    modport slave (
        output enable, miso,
        input  cs_n, sclk, raw_sample, adc_data, adc_valid, busy
    );
endinterface

// File: rtl/spi_adc_sampler.sv
// Periodic AD7476-class conversion engine with 2^AVG_LOG2 box averaging into a
// left-justified 16-bit result word.
module spi_adc_sampler #(
    parameter int CLK_DIV       = 5,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int QUIET_CYCLES  = 5,
    parameter int AVG_LOG2      = 2
) (
    input logic               clk,
    input logic               reset,
    spi_adc_sampler_if.master bus
);
    localparam int HW = $clog2(CLK_DIV);
    localparam int RW = $clog2(SAMPLE_PERIOD);
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, CONV, QUIET} state_t;
    state_t state, state_nxt;

    logic [RW-1:0] rcnt;
    logic [HW-1:0] hcnt;
    logic [5:0]    ticks;
    logic [QW-1:0] qcnt;
    logic          sclk_q;
    logic [11:0]   shift;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [11:0]   raw_q;
    logic [15:0]   data_q;
    logic          valid_q;
    logic          start, hc_done, capture;
    logic [AW-1:0] sum;

    assign start   = bus.enable && (rcnt == '0);
    assign hc_done = (hcnt == HW'(CLK_DIV - 1));
    assign capture = (state == QUIET) && (qcnt == '0);
    assign sum     = acc + AW'(shift);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ticks counts completed half-periods; 32 toggles, then one extra H of sclk high.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (hc_done && ticks == 6'd32) state_nxt = QUIET;
            QUIET:   if (qcnt == QW'(QUIET_CYCLES - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.cs_n = (state != CONV);
        bus.busy = (state != IDLE);
    end

    assign bus.sclk       = sclk_q;
    assign bus.raw_sample = raw_q;
    assign bus.adc_data   = data_q;
    assign bus.adc_valid  = valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                              rcnt <= '0;
        else if (!bus.enable || rcnt == RW'(SAMPLE_PERIOD - 1)) rcnt <= '0;
        else                                                    rcnt <= rcnt + RW'(1);
    end

    // Only the 12 data bits are kept; the 4 leading bits shift out of the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt   <= '0;
            ticks  <= '0;
            sclk_q <= 1'b1;
            shift  <= '0;
        end else if (state == CONV) begin
            hcnt <= hc_done ? '0 : hcnt + HW'(1);
            if (hc_done) begin
                ticks <= ticks + 6'd1;
                if (ticks < 6'd32) begin
                    sclk_q <= ~sclk_q;
                    if (!sclk_q) shift <= {shift[10:0], bus.miso};
                end
            end
        end else begin
            hcnt   <= '0;
            ticks  <= '0;
            sclk_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               qcnt <= '0;
        else if (state == QUIET) qcnt <= qcnt + QW'(1);
        else                     qcnt <= '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            cnt     <= '0;
            raw_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (capture) begin
                raw_q <= shift;
                if (cnt == CW'((1 << AVG_LOG2) - 1)) begin
                    data_q  <= {sum[AW-1:AVG_LOG2], 4'h0};
                    valid_q <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CW'(1);
                end
            end else if (state == IDLE && !bus.enable) begin
                acc <= '0;
                cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_spi_adc_sampler.sv
// Three sampler configurations (single, averaged, overrun) against a timing/averaging
// reference model driven by random ADC words plus a few directed ones.
module tb_spi_adc_sampler;
    localparam int N = 3;
    localparam int H_P  [N] = '{5, 3, 5};
    localparam int SP_P [N] = '{200, 200, 100};
    localparam int Q_P  [N] = '{5, 2, 5};
    localparam int A_P  [N] = '{0, 2, 0};

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0]       en, miso_d;
    logic [N-1:0]       cs_n_o, sclk_o, valid_o, busy_o;
    logic [N-1:0][11:0] raw_o;
    logic [N-1:0][15:0] data_o;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        spi_adc_sampler_if bus ();
        spi_adc_sampler #(
            .CLK_DIV(H_P[g]), .SAMPLE_PERIOD(SP_P[g]),
            .QUIET_CYCLES(Q_P[g]), .AVG_LOG2(A_P[g])
        ) u_dut (
            .clk(clk), .reset(reset), .bus(bus)
        );
        assign bus.enable = en[g];
        assign bus.miso   = miso_d[g];
        assign cs_n_o[g]  = bus.cs_n;
        assign sclk_o[g]  = bus.sclk;
        assign valid_o[g] = bus.adc_valid;
        assign busy_o[g]  = bus.busy;
        assign raw_o[g]   = bus.raw_sample;
        assign data_o[g]  = bus.adc_data;
    end

    int n_cmp = 0, n_mis = 0, cyc = 0;

    // reference model state, one slot per configuration
    int          run_len[N], free_at[N], t0[N], tog[N], rises[N], cap_at[N];
    int          win_sum[N], win_n[N], dir_i[N], dir_n[N];
    logic        exp_start[N], in_conv[N], bad[N], prev_cs[N], prev_sclk[N];
    logic [15:0] word[N];
    logic [11:0] raw_exp[N];
    logic [15:0] dir_w[N][4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Decide what happens at the coming rising edge from the current inputs.
    task automatic predict();
        for (int i = 0; i < N; i++) begin
            exp_start[i] = 1'b0;
            if (reset) begin
                run_len[i] = 0; free_at[i] = 0; in_conv[i] = 1'b0; cap_at[i] = -1;
                win_sum[i] = 0; win_n[i] = 0;
            end else if (en[i]) begin
                if (run_len[i] % SP_P[i] == 0 && cyc + 1 >= free_at[i]) begin
                    exp_start[i] = 1'b1;
                    free_at[i]   = cyc + 1 + 33 * H_P[i] + Q_P[i] + 1;
                end
                run_len[i]++;
            end else begin
                run_len[i] = 0;
                if (cyc + 1 >= free_at[i]) begin
                    win_sum[i] = 0; win_n[i] = 0;
                end
            end
        end
    endtask

    task automatic observe();
        logic fall, rise, exp_v;
        logic [15:0] exp_d;
        cyc++;
        for (int i = 0; i < N; i++) begin
            fall = prev_cs[i] && !cs_n_o[i];
            rise = !prev_cs[i] && cs_n_o[i];
            if (!reset) begin
                if (fall || exp_start[i]) chk($sformatf("u%0d.cs_fall", i), fall, exp_start[i]);
                if (fall) begin
                    t0[i] = cyc; in_conv[i] = 1'b1; tog[i] = 0; rises[i] = 0; bad[i] = 1'b0;
                    if (dir_i[i] < dir_n[i]) begin
                        word[i] = dir_w[i][dir_i[i]];
                        dir_i[i]++;
                    end else begin
                        word[i] = 16'($urandom);
                    end
                    miso_d[i] = 1'($urandom);
                end
                if (in_conv[i] && sclk_o[i] != prev_sclk[i]) begin
                    tog[i]++;
                    if (cyc - t0[i] != tog[i] * H_P[i]) bad[i] = 1'b1;
                    if (sclk_o[i]) rises[i]++;
                    else if (tog[i] <= 32) miso_d[i] = word[i][16 - (tog[i] + 1) / 2];
                end
                if (rise && in_conv[i]) begin
                    chk($sformatf("u%0d.cs_low_width", i), cyc - t0[i], 33 * H_P[i]);
                    chk($sformatf("u%0d.sclk_rises", i), rises[i], 16);
                    chk($sformatf("u%0d.sclk_timing", i), bad[i], 0);
                    in_conv[i] = 1'b0;
                    cap_at[i]  = cyc + 1;
                    raw_exp[i] = word[i][11:0];
                end
                exp_v = 1'b0;
                exp_d = '0;
                if (cyc == cap_at[i]) begin
                    chk($sformatf("u%0d.raw_sample", i), raw_o[i], raw_exp[i]);
                    win_sum[i] += int'(raw_exp[i]);
                    win_n[i]++;
                    if (win_n[i] == (1 << A_P[i])) begin
                        exp_v = 1'b1;
                        exp_d = {12'(win_sum[i] >> A_P[i]), 4'h0};
                        win_sum[i] = 0; win_n[i] = 0;
                    end
                end
                if (valid_o[i] || exp_v) chk($sformatf("u%0d.adc_valid", i), valid_o[i], exp_v);
                if (exp_v) chk($sformatf("u%0d.adc_data", i), data_o[i], exp_d);
            end
            prev_cs[i]   = cs_n_o[i];
            prev_sclk[i] = sclk_o[i];
        end
    endtask

    task automatic tick();
        predict();
        @(negedge clk);
        observe();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic reset_values();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d.rst_cs_n", i), cs_n_o[i], 1);
            chk($sformatf("u%0d.rst_sclk", i), sclk_o[i], 1);
            chk($sformatf("u%0d.rst_raw", i), raw_o[i], 0);
            chk($sformatf("u%0d.rst_data", i), data_o[i], 0);
            chk($sformatf("u%0d.rst_valid", i), valid_o[i], 0);
            chk($sformatf("u%0d.rst_busy", i), busy_o[i], 0);
        end
    endtask

    initial begin
        reset = 1'b1; en = '0; miso_d = '0;
        for (int i = 0; i < N; i++) begin
            run_len[i] = 0; free_at[i] = 0; cap_at[i] = -1; in_conv[i] = 1'b0;
            win_sum[i] = 0; win_n[i] = 0; dir_i[i] = 0; dir_n[i] = 0;
            prev_cs[i] = 1'b1; prev_sclk[i] = 1'b1; exp_start[i] = 1'b0;
            tog[i] = 0; rises[i] = 0; t0[i] = 0; bad[i] = 1'b0; word[i] = '0; raw_exp[i] = '0;
            for (int j = 0; j < 4; j++) dir_w[i][j] = '0;
        end
        dir_w[0][0] = 16'h0ABC; dir_w[0][1] = 16'hFFFF; dir_w[0][2] = 16'hF000; dir_n[0] = 3;
        dir_w[1][0] = 16'h0100; dir_w[1][1] = 16'h0200; dir_w[1][2] = 16'h0300;
        dir_w[1][3] = 16'h0404; dir_n[1] = 4;

        run(4);
        reset_values();
        reset = 1'b0;
        en    = '1;
        run(1300);

        // averaged config: drop enable with two conversions in the window
        for (int k = 0; k < 3000 && win_n[1] != 2; k++) tick();
        chk("u1.wait_partial", win_n[1], 2);
        en[1] = 1'b0;

        // single config: drop enable in the middle of a conversion
        for (int k = 0; k < 3000 && !(in_conv[0] && cyc - t0[0] > 20); k++) tick();
        chk("u0.wait_conv", in_conv[0], 1);
        en[0] = 1'b0;
        run(400);
        en = '1;
        run(1000);

        // asynchronous reset mid-conversion
        for (int k = 0; k < 3000 && !(in_conv[0] && cyc - t0[0] > 50); k++) tick();
        chk("u0.wait_conv2", in_conv[0], 1);
        reset = 1'b1;
        #1;
        reset_values();
        run(3);
        reset = 1'b0;
        run(1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
